// File: rtl/cache_control.sv
// cache_control: control FSM for a direct-mapped L1 cache (8 lines x 128 bits).
// Sequences the line arrays through hit, write-back and allocate. Handshakes with
// the CPU port and the physical-memory port. Keeps saturating hit/miss counters.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cpu_read, cpu_write              CPU requests, held until cpu_resp
//   cpu_resp                         one-cycle completion pulse to the CPU
//   hit, line_valid, line_dirty      datapath status for the indexed line
//   pmem_resp                        physical memory done
//   pmem_read, pmem_write            physical memory line requests
//   load_data/tag/valid/dirty        array write enables
//   valid_in, dirty_in               values written to the valid/dirty arrays
//   data_sel                         0 = merge CPU write data, 1 = line from pmem
//   addr_sel                         0 = {cpu tag,index}, 1 = {stored tag,index}
//   busy                             FSM not idle
//   count_clr                        synchronous clear of both counters
//   hit_count, miss_count            saturating performance counters
// Control outputs are combinational from state and inputs, so a hit answers in
// the COMPARE cycle itself.
module cache_control #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_read,
  input  logic               cpu_write,
  output logic               cpu_resp,
  input  logic               hit,
  input  logic               line_valid,
  input  logic               line_dirty,
  input  logic               pmem_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic               load_data,
  output logic               load_tag,
  output logic               load_valid,
  output logic               load_dirty,
  output logic               valid_in,
  output logic               dirty_in,
  output logic               data_sel,
  output logic               addr_sel,
  output logic               busy,
  input  logic               count_clr,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPARE   = 2'd1,
    S_WRITEBACK = 2'd2,
    S_ALLOCATE  = 2'd3
  } state_e;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic                 first_q, first_d;
  logic [COUNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [COUNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic                 hit_inc, miss_inc;
  logic                 req;

  assign req = cpu_read | cpu_write;

  // State, first-pass flag and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      first_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_d    = state_q;
    cpu_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    load_data  = 1'b0;
    load_tag   = 1'b0;
    load_valid = 1'b0;
    load_dirty = 1'b0;
    valid_in   = 1'b0;
    dirty_in   = 1'b0;
    data_sel   = 1'b0;
    addr_sel   = 1'b0;
    busy       = (state_q != S_IDLE);
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (!req) begin
          state_d = S_IDLE;
        end else if (hit) begin
          cpu_resp = 1'b1;
          hit_inc  = 1'b1;
          state_d  = S_IDLE;
          // Read+write together is treated as a write
          if (cpu_write) begin
            load_data  = 1'b1;
            load_dirty = 1'b1;
            dirty_in   = 1'b1;
          end
        end else begin
          // Only the COMPARE entered from IDLE counts as a miss
          miss_inc = first_q;
          state_d  = (line_valid && line_dirty) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        pmem_write = 1'b1;
        addr_sel   = 1'b1;
        if (pmem_resp) state_d = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_data  = 1'b1;
          data_sel   = 1'b1;
          load_tag   = 1'b1;
          load_valid = 1'b1;
          valid_in   = 1'b1;
          load_dirty = 1'b1;
          state_d    = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // First-pass flag is high in a COMPARE cycle entered from IDLE
  always_comb begin
    first_d = (state_q == S_IDLE);
  end

  // Saturating counters; clear wins over a same-cycle increment
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (count_clr) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else begin
      if (hit_inc && (hit_cnt_q != CNT_MAX))   hit_cnt_d  = hit_cnt_q + COUNT_W'(1);
      if (miss_inc && (miss_cnt_q != CNT_MAX)) miss_cnt_d = miss_cnt_q + COUNT_W'(1);
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control with a response scoreboard and a counter model.
module tb_cache_control;

  localparam int unsigned COUNT_W = 16;

  logic               clk;
  logic               rst_n;
  logic               cpu_read, cpu_write, cpu_resp;
  logic               hit, line_valid, line_dirty, pmem_resp;
  logic               pmem_read, pmem_write;
  logic               load_data, load_tag, load_valid, load_dirty;
  logic               valid_in, dirty_in, data_sel, addr_sel, busy;
  logic               count_clr;
  logic [COUNT_W-1:0] hit_count, miss_count;
  logic [11:0]        outs;

  typedef struct {
    int   lat;
    logic wr;
  } exp_t;

  exp_t              exp_q[$];
  int                checks;
  int                failures;
  logic [COUNT_W-1:0] exp_hits, exp_miss;

  cache_control #(.COUNT_W(COUNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_resp   (cpu_resp),
    .hit        (hit),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .pmem_resp  (pmem_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .load_data  (load_data),
    .load_tag   (load_tag),
    .load_valid (load_valid),
    .load_dirty (load_dirty),
    .valid_in   (valid_in),
    .dirty_in   (dirty_in),
    .data_sel   (data_sel),
    .addr_sel   (addr_sel),
    .busy       (busy),
    .count_clr  (count_clr),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  assign outs = {cpu_resp, pmem_read, pmem_write, load_data, load_tag, load_valid,
                 load_dirty, valid_in, dirty_in, data_sel, addr_sel, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] x);
    return (x == {COUNT_W{1'b1}}) ? x : x + COUNT_W'(1);
  endfunction

  task automatic check_counters(input string tag);
    chk({tag, "_hits"}, 32'(hit_count), 32'(exp_hits));
    chk({tag, "_miss"}, 32'(miss_count), 32'(exp_miss));
  endtask

  // One CPU request; called just after a rising edge. Acts as the datapath and
  // pmem: the line becomes a valid clean hit once it has been filled.
  task automatic run_req(input string tag, input logic rd, input logic wr,
                         input logic h, input logic v, input logic d,
                         input int wb, input int al, input logic clr);
    int   n, kw, ka;
    logic done, filled;
    exp_t e, got;
    e.lat = h ? 1 : ((v && d) ? 2 + wb + al : 2 + al);
    e.wr  = wr;
    exp_q.push_back(e);
    if (!h) exp_miss = sat_inc(exp_miss);
    exp_hits = sat_inc(exp_hits);
    if (clr) begin
      exp_hits = '0;
      exp_miss = '0;
    end
    cpu_read = rd; cpu_write = wr; hit = h; line_valid = v; line_dirty = d;
    n = 0; kw = 0; ka = 0; done = 1'b0;
    while (!done && n < 60) begin
      #1;
      filled = 1'b0;
      chk({tag, "_pmem_excl"}, 32'(pmem_read & pmem_write), 32'd0);
      if (pmem_write) begin
        kw++;
        chk({tag, "_wb_addr_sel"}, 32'(addr_sel), 32'd1);
        pmem_resp = (kw == wb);
      end else if (pmem_read) begin
        ka++;
        chk({tag, "_al_addr_sel"}, 32'(addr_sel), 32'd0);
        pmem_resp = (ka == al);
      end else begin
        pmem_resp = 1'b0;
      end
      #1;
      if (pmem_read && pmem_resp) begin
        filled = 1'b1;
        chk({tag, "_fill"},
            32'({load_data, data_sel, load_tag, load_valid, valid_in, load_dirty, dirty_in}),
            32'(7'b1111110));
      end
      if (cpu_resp) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_unexpected_resp"}, 32'd1, 32'd0);
        end else begin
          got = exp_q.pop_front();
          chk({tag, "_latency"}, 32'(n), 32'(got.lat));
          chk({tag, "_resp_loads"}, 32'({load_data, load_dirty, dirty_in, data_sel}),
              got.wr ? 32'(4'b1110) : 32'(4'b0000));
        end
        count_clr = clr;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      pmem_resp = 1'b0;
      count_clr = 1'b0;
      if (filled) begin
        hit = 1'b1; line_valid = 1'b1; line_dirty = 1'b0;
      end
      if (done) begin
        cpu_read = 1'b0; cpu_write = 1'b0;
      end
    end
    if (!done) begin
      chk({tag, "_resp_timeout"}, 32'(n), 32'd0);
      void'(exp_q.pop_front());
      cpu_read = 1'b0; cpu_write = 1'b0;
    end
    #1;
    chk({tag, "_idle_after"}, 32'(outs), 32'd0);
    check_counters(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    exp_hits = '0; exp_miss = '0;
    rst_n = 1'b0;
    cpu_read = 1'b0; cpu_write = 1'b0; hit = 1'b0; line_valid = 1'b0;
    line_dirty = 1'b0; pmem_resp = 1'b0; count_clr = 1'b0;
    #1;
    chk("reset_outs", 32'(outs), 32'd0);
    check_counters("reset");
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Read hit, clean read miss, dirty read miss
    run_req("read_hit",   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    run_req("clean_miss", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 5, 1'b0);
    run_req("dirty_miss", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, 2, 1'b0);
    // Writes: hit, read+write together, clean write miss
    run_req("write_hit",  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    run_req("rw_hit",     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
    run_req("write_miss", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 3, 1'b0);

    // Request dropped before COMPARE: no response, nothing counted
    cpu_write = 1'b1; hit = 1'b1; line_valid = 1'b1;
    @(posedge clk);
    #1;
    cpu_write = 1'b0;
    #1;
    chk("drop_resp", 32'({cpu_resp, busy}), 32'(2'b01));
    @(posedge clk);
    #1;
    chk("drop_idle", 32'(outs), 32'd0);
    check_counters("drop");

    // Reset in the middle of ALLOCATE
    cpu_read = 1'b1; hit = 1'b0; line_valid = 1'b0; line_dirty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_alloc_pre", 32'({pmem_read, busy}), 32'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_alloc_outs", 32'(outs), 32'd0);
    exp_hits = '0; exp_miss = '0;
    check_counters("rst_mid_alloc");
    cpu_read = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_release_idle", 32'(outs), 32'd0);
    @(posedge clk);
    #1;

    // Hit counter saturation, then clear against a same-cycle hit
    force dut.hit_cnt_q = 16'hFFFF;
    #1;
    release dut.hit_cnt_q;
    exp_hits = 16'hFFFF;
    #1;
    chk("force_hits", 32'(hit_count), 32'h0000FFFF);
    run_req("sat_hit",    1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    run_req("sat_miss",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0);
    run_req("clr_hit",    1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
